// File: rtl/coco_cycle_capture_pkg.sv
// Shared constants and types for the CoCo cartridge-bus capture front end
// and the cocofdc register logic behind it.
package coco_cycle_capture_pkg;

  // Register window decoded by SCS on the CoCo side
  localparam logic [15:0] CC_REG_BASE = 16'hFF40;
  localparam logic [15:0] CC_REG_LAST = 16'hFF5F;

  // Event field widths
  localparam int unsigned CC_ADDR_BITS  = 5;
  localparam int unsigned CC_DATA_W     = 8;
  localparam int unsigned CC_BUS_ADDR_W = 16;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_COMMIT = 2'd2
  } cc_state_e;

  // One sample of the CoCo pins, carried together through the synchroniser
  typedef struct packed {
    logic                     e;
    logic                     scs_n;
    logic                     rw;
    logic [CC_BUS_ADDR_W-1:0] addr;
    logic [CC_DATA_W-1:0]     data;
  } cc_pins_t;

  // Event word width: {rw, addr, data}
  function automatic int unsigned cc_evt_width(input int unsigned addr_bits);
    return addr_bits + 1 + CC_DATA_W;
  endfunction

endpackage

// File: rtl/coco_cycle_capture_if.sv
// CoCo bus pins plus the event-queue consumer side of coco_cycle_capture.
interface coco_cycle_capture_if
  import coco_cycle_capture_pkg::*;
#(
  parameter int unsigned ADDR_BITS = CC_ADDR_BITS,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                     c_eclk;
  logic                     c_scs_n;
  logic                     c_rw;
  logic [CC_BUS_ADDR_W-1:0] c_addrbus;
  logic [CC_DATA_W-1:0]     c_databus_in;
  logic                     c_power;
  logic                     pop;
  logic                     ovf_clr;
  logic                     evt_valid;
  logic                     evt_rw;
  logic [ADDR_BITS-1:0]     evt_addr;
  logic [CC_DATA_W-1:0]     evt_data;
  logic [CW-1:0]            evt_count;
  logic                     overflow;
  logic [7:0]               drop_count;
  logic                     intr;

  modport master (
    output c_eclk, c_scs_n, c_rw, c_addrbus, c_databus_in, c_power, pop, ovf_clr,
    input  evt_valid, evt_rw, evt_addr, evt_data, evt_count, overflow, drop_count, intr
  );

  modport slave (
    input  c_eclk, c_scs_n, c_rw, c_addrbus, c_databus_in, c_power, pop, ovf_clr,
    output evt_valid, evt_rw, evt_addr, evt_data, evt_count, overflow, drop_count, intr
  );

endinterface

// File: rtl/coco_evt_fifo.sv
// Generic synchronous FIFO with flush; head entry is presented combinationally.
module coco_evt_fifo
  import coco_cycle_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = cc_evt_width(CC_ADDR_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count update; pop only when non-empty, push when room or popping
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    dout  = mem_q[rd_ptr_q];
    count = count_q;
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/coco_cycle_capture.sv
// CoCo cartridge-bus capture: synchronise pins, filter E, turn each
// SCS-qualified register access into one queued event for the FDC core.
module coco_cycle_capture
  import coco_cycle_capture_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = CC_ADDR_BITS,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 8
) (
  input  logic                 clock_50,
  input  logic                 reset,
  coco_cycle_capture_if.slave  bus
);
  localparam int unsigned EW = cc_evt_width(ADDR_BITS);
  localparam int unsigned HW = $clog2(MIN_HIGH + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  cc_pins_t sync_q [SYNC_STAGES];
  cc_pins_t sync_d [SYNC_STAGES];
  logic     e_s, scs_s, rw_s;
  logic [CC_BUS_ADDR_W-1:0] addr_s;
  logic [CC_DATA_W-1:0]     data_s;
  logic     unused_addr_hi;

  cc_state_e            state_q, state_d;
  logic [HW-1:0]        hi_cnt_q, hi_cnt_d;
  logic                 hold_sel_q, hold_sel_d;
  logic                 hold_rw_q, hold_rw_d;
  logic [ADDR_BITS-1:0] hold_addr_q, hold_addr_d;
  logic [CC_DATA_W-1:0] hold_data_q, hold_data_d;
  logic                 push;
  logic [CC_DATA_W-1:0] push_data;
  logic [EW-1:0]        fifo_din, fifo_dout;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 drop;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  // Synchroniser chain: all pins travel together so they stay skew-aligned
  always_comb begin
    sync_d[0] = '{e: bus.c_eclk, scs_n: bus.c_scs_n, rw: bus.c_rw,
                  addr: bus.c_addrbus, data: bus.c_databus_in};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    e_s            = sync_q[SYNC_STAGES-1].e;
    scs_s          = ~sync_q[SYNC_STAGES-1].scs_n;
    rw_s           = sync_q[SYNC_STAGES-1].rw;
    addr_s         = sync_q[SYNC_STAGES-1].addr;
    data_s         = sync_q[SYNC_STAGES-1].data;
    unused_addr_hi = ^addr_s[CC_BUS_ADDR_W-1:ADDR_BITS];
  end

  // Synchroniser registers
  always_ff @(posedge clock_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  // Capture FSM: qualify the E-high width, keep the latest SCS snapshot, commit on the fall
  always_comb begin
    state_d     = state_q;
    hi_cnt_d    = hi_cnt_q;
    hold_sel_d  = hold_sel_q;
    hold_rw_d   = hold_rw_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    push        = 1'b0;
    if (!bus.c_power) begin
      state_d    = ST_IDLE;
      hold_sel_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (e_s) begin
            state_d  = ST_HIGH;
            hi_cnt_d = '0;
          end
        end
        ST_HIGH: begin
          if (e_s) begin
            if (hi_cnt_q < HW'(MIN_HIGH)) begin
              hi_cnt_d = hi_cnt_q + 1'b1;
            end
            if (scs_s) begin
              hold_rw_d   = rw_s;
              hold_addr_d = addr_s[ADDR_BITS-1:0];
              hold_data_d = data_s;
              hold_sel_d  = 1'b1;
            end
          end else begin
            if ((hi_cnt_q >= HW'(MIN_HIGH)) && hold_sel_q) begin
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_IDLE;
            end
            hold_sel_d = 1'b0;
          end
        end
        ST_COMMIT: begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and hold registers
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hi_cnt_q    <= '0;
      hold_sel_q  <= 1'b0;
      hold_rw_q   <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hi_cnt_q    <= hi_cnt_d;
      hold_sel_q  <= hold_sel_d;
      hold_rw_q   <= hold_rw_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Event word; reads carry no data
  always_comb begin
    push_data = hold_rw_q ? '0 : hold_data_q;
    fifo_din  = {hold_rw_q, hold_addr_q, push_data};
  end

  coco_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clock_50),
    .rst   (reset),
    .flush (~bus.c_power),
    .push  (push),
    .pop   (bus.pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Drop accounting; a drop in the same cycle as a clear restarts the count at 1
  always_comb begin
    drop       = push & fifo_full & ~bus.pop;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.ovf_clr) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Overflow status registers
  always_ff @(posedge clock_50) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Consumer-side outputs
  always_comb begin
    bus.evt_valid  = ~fifo_empty;
    bus.evt_rw     = fifo_dout[EW-1];
    bus.evt_addr   = fifo_dout[EW-2 -: ADDR_BITS];
    bus.evt_data   = fifo_dout[CC_DATA_W-1:0];
    bus.evt_count  = fifo_count;
    bus.overflow   = overflow_q;
    bus.drop_count = drop_cnt_q;
    bus.intr       = ~fifo_empty | overflow_q;
  end

endmodule

// File: tb/tb_coco_cycle_capture.sv
// Bench for coco_cycle_capture: directed table, multi-cycle corner sequences,
// and randomized CoCo cycles against a queue-based event model.
module tb_coco_cycle_capture;
  import coco_cycle_capture_pkg::*;

  localparam int unsigned ADDR_BITS   = 5;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MIN_HIGH    = 8;
  localparam int unsigned EW          = ADDR_BITS + 9;

  logic clk;
  logic rst;

  coco_cycle_capture_if #(.ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH)) bus ();

  coco_cycle_capture #(
    .ADDR_BITS   (ADDR_BITS),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_HIGH    (MIN_HIGH)
  ) dut (
    .clock_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rand_ctl = 1'b0;

  // Reference model: event queue, sticky overflow, drop counter, scheduled pushes
  logic [EW-1:0] mq [$];
  bit            m_ovf;
  int            m_dcnt;
  int            push_at [$];
  logic [EW-1:0] push_ev [$];

  typedef struct {
    bit            rw;
    logic [15:0]   addr;
    logic [7:0]    data;
    bit            scs_n;
    int unsigned   high;
    bit            exp_evt;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit pw, input bit pp, input bit cl);
    bit            do_push;
    bit            drop;
    logic [EW-1:0] ev;
    do_push = 1'b0;
    drop    = 1'b0;
    ev      = '0;
    if (push_at.size() > 0 && push_at[0] == cyc) begin
      do_push = 1'b1;
      ev      = push_ev.pop_front();
      void'(push_at.pop_front());
    end
    if (r) begin
      mq.delete();
      push_at.delete();
      push_ev.delete();
      m_ovf  = 1'b0;
      m_dcnt = 0;
      return;
    end
    if (!pw) begin
      mq.delete();
      do_push = 1'b0;
    end
    if (pp && mq.size() > 0) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() >= DEPTH) drop = 1'b1;
      else mq.push_back(ev);
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_dcnt = cl ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
    end else if (cl) begin
      m_ovf  = 1'b0;
      m_dcnt = 0;
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(bus.evt_valid), 32'(mq.size() > 0));
    check("count", 32'(bus.evt_count), 32'(mq.size()));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("drop_count", 32'(bus.drop_count), 32'(m_dcnt));
    check("intr", 32'(bus.intr), 32'((mq.size() > 0) || m_ovf));
    if (mq.size() > 0)
      check("head", 32'({bus.evt_rw, bus.evt_addr, bus.evt_data}), 32'(mq[0]));
  endtask

  // One clock: capture the inputs the edge will see, advance, update model, compare
  task automatic tick();
    bit r, pw, pp, cl;
    if (rand_ctl) begin
      bus.pop     = ($urandom_range(0, 2) == 0);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
    end
    r  = rst;
    pw = bus.c_power;
    pp = bus.pop;
    cl = bus.ovf_clr;
    @(posedge clk);
    cyc++;
    #1;
    model_step(r, pw, pp, cl);
    compare_all();
  endtask

  // Hold E high for 'high' clocks with stable bus pins, then drop E
  task automatic e_high(input bit rw, input logic [15:0] addr, input logic [7:0] data,
                        input bit scs_n, input int unsigned high);
    bus.c_rw         = rw;
    bus.c_addrbus    = addr;
    bus.c_databus_in = data;
    bus.c_scs_n      = scs_n;
    bus.c_eclk       = 1'b1;
    repeat (high) tick();
    bus.c_eclk = 1'b0;
    if (high > MIN_HIGH && !scs_n && bus.c_power) begin
      push_at.push_back(cyc + SYNC_STAGES + 2);
      push_ev.push_back({rw, addr[ADDR_BITS-1:0], rw ? 8'h00 : data});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.evt_valid), 0);
    check({tag, "_rw"}, 32'(bus.evt_rw), 0);
    check({tag, "_addr"}, 32'(bus.evt_addr), 0);
    check({tag, "_data"}, 32'(bus.evt_data), 0);
    check({tag, "_count"}, 32'(bus.evt_count), 0);
    check({tag, "_ovf"}, 32'(bus.overflow), 0);
    check({tag, "_drops"}, 32'(bus.drop_count), 0);
    check({tag, "_intr"}, 32'(bus.intr), 0);
  endtask

  initial begin
    logic [7:0]  exp_order [4];
    int unsigned high;

    vecs[0] = '{1'b0, 16'hFF48, 8'hA5, 1'b0, 28, 1'b1, {1'b0, 5'h08, 8'hA5}};
    vecs[1] = '{1'b1, 16'hFF4B, 8'h3C, 1'b0, 28, 1'b1, {1'b1, 5'h0B, 8'h00}};
    vecs[2] = '{1'b0, 16'hFF41, 8'h11, 1'b1, 28, 1'b0, '0};
    vecs[3] = '{1'b0, 16'hFF44, 8'h22, 1'b0, 3,  1'b0, '0};
    vecs[4] = '{1'b0, 16'hFF5F, 8'h5A, 1'b0, 12, 1'b1, {1'b0, 5'h1F, 8'h5A}};
    exp_order = '{8'h11, 8'h12, 8'h13, 8'h16};

    rst              = 1'b1;
    bus.c_eclk       = 1'b0;
    bus.c_scs_n      = 1'b1;
    bus.c_rw         = 1'b1;
    bus.c_addrbus    = '0;
    bus.c_databus_in = '0;
    bus.c_power      = 1'b1;
    bus.pop          = 1'b0;
    bus.ovf_clr      = 1'b0;

    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    repeat (4) tick();

    // Directed table: latency, fields, filtering
    foreach (vecs[i]) begin
      e_high(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].scs_n, vecs[i].high);
      repeat (SYNC_STAGES + 1) tick();
      check("tbl_early_valid", 32'(bus.evt_valid), 0);
      tick();
      check("tbl_valid", 32'(bus.evt_valid), 32'(vecs[i].exp_evt));
      check("tbl_count", 32'(bus.evt_count), 32'(vecs[i].exp_evt));
      if (vecs[i].exp_evt) begin
        check("tbl_evt", 32'({bus.evt_rw, bus.evt_addr, bus.evt_data}), 32'(vecs[i].exp));
        check("tbl_intr", 32'(bus.intr), 1);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
      end
      repeat (4) tick();
    end

    // Six writes without popping: four kept, two dropped
    for (int i = 0; i < 6; i++) begin
      e_high(1'b0, CC_REG_BASE + 16'(i), 8'h10 + 8'(i), 1'b0, 20);
      repeat (8) tick();
    end
    check("ovf6_count", 32'(bus.evt_count), 4);
    check("ovf6_overflow", 32'(bus.overflow), 1);
    check("ovf6_drops", 32'(bus.drop_count), 2);
    check("ovf6_head", 32'({bus.evt_rw, bus.evt_addr, bus.evt_data}), 32'({1'b0, 5'h00, 8'h10}));

    // Seventh write lands together with a pop while full
    e_high(1'b0, CC_REG_BASE + 16'd6, 8'h16, 1'b0, 20);
    repeat (SYNC_STAGES + 1) tick();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("fullpp_count", 32'(bus.evt_count), 4);
    check("fullpp_drops", 32'(bus.drop_count), 2);
    for (int j = 0; j < 4; j++) begin
      check("order_data", 32'(bus.evt_data), 32'(exp_order[j]));
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
    end
    check("drained_count", 32'(bus.evt_count), 0);
    check("drained_intr", 32'(bus.intr), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("clr_overflow", 32'(bus.overflow), 0);
    check("clr_drops", 32'(bus.drop_count), 0);

    // Push and pop together while empty: push accepted
    e_high(1'b1, 16'hFF4C, 8'h77, 1'b0, 15);
    repeat (SYNC_STAGES + 1) tick();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("emptypp_count", 32'(bus.evt_count), 1);
    check("emptypp_evt", 32'({bus.evt_rw, bus.evt_addr, bus.evt_data}), 32'({1'b1, 5'h0C, 8'h00}));
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;

    // Fill, then a drop coinciding with ovf_clr
    for (int i = 0; i < 4; i++) begin
      e_high(1'b0, CC_REG_BASE + 16'(8 + i), 8'hC0 + 8'(i), 1'b0, 16);
      repeat (8) tick();
    end
    e_high(1'b0, 16'hFF4F, 8'hEE, 1'b0, 16);
    repeat (SYNC_STAGES + 1) tick();
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("dropclr_overflow", 32'(bus.overflow), 1);
    check("dropclr_drops", 32'(bus.drop_count), 1);
    check("dropclr_count", 32'(bus.evt_count), 4);

    // Power loss for one clock flushes events, keeps drop status
    bus.c_power = 1'b0;
    tick();
    bus.c_power = 1'b1;
    check("pwr_valid", 32'(bus.evt_valid), 0);
    check("pwr_count", 32'(bus.evt_count), 0);
    check("pwr_drops", 32'(bus.drop_count), 1);
    check("pwr_overflow", 32'(bus.overflow), 1);
    repeat (3) tick();

    // One queued write, then reset in the middle of an E-high phase
    e_high(1'b0, 16'hFF42, 8'h3E, 1'b0, 14);
    repeat (8) tick();
    check("pre_rst_count", 32'(bus.evt_count), 1);
    bus.c_rw         = 1'b0;
    bus.c_addrbus    = 16'hFF50;
    bus.c_databus_in = 8'h99;
    bus.c_scs_n      = 1'b0;
    bus.c_eclk       = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    repeat (3) tick();
    bus.c_eclk = 1'b0;
    repeat (8) tick();
    check("midrst_noevt_valid", 32'(bus.evt_valid), 0);
    check("midrst_noevt_drops", 32'(bus.drop_count), 0);

    // Randomized cycles with random pops and clears
    rand_ctl = 1'b1;
    for (int i = 0; i < 150; i++) begin
      high = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : $urandom_range(12, 30);
      e_high(1'($urandom_range(0, 1)), CC_REG_BASE | 16'($urandom_range(0, 31)),
             8'($urandom), ($urandom_range(0, 3) == 0), high);
      repeat ($urandom_range(6, 10)) tick();
    end
    rand_ctl    = 1'b0;
    bus.pop     = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
